// File: rtl/smbm_ctrl.sv
// smbm_ctrl: round-robin sequencer issuing ADD/DELETE/READ to one smbm instance,
// tracking occupancy, rejecting overflow/underflow and watchdogging sm_done.
module smbm_ctrl #(
    parameter int BIT_VEC_SIZE       = 256,
    parameter int BIT_VEC_SIZE_LOG   = 8,
    parameter int NUM_OF_METRICS     = 4,
    parameter int NUM_OF_METRICS_LOG = 2,
    parameter int TIMEOUT            = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic                          upd_op,
    input  logic [BIT_VEC_SIZE_LOG-1:0]   upd_id,
    input  logic [8*NUM_OF_METRICS-1:0]   upd_metric,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [BIT_VEC_SIZE-1:0]       rd_mask,
    input  logic [NUM_OF_METRICS_LOG-1:0] rd_metric,
    input  logic                          rd_filter,
    output logic [2:0]                    sm_opcode,
    output logic [BIT_VEC_SIZE_LOG-1:0]   sm_id,
    output logic [8*NUM_OF_METRICS-1:0]   sm_metric_val,
    output logic [BIT_VEC_SIZE-1:0]       sm_in,
    output logic [NUM_OF_METRICS_LOG-1:0] sm_metricX,
    output logic [2:0]                    sm_opcode_in,
    input  logic                          sm_done,
    output logic                          rsp_valid,
    output logic [1:0]                    rsp_kind,
    output logic [1:0]                    rsp_status,
    output logic [BIT_VEC_SIZE_LOG:0]     occupancy,
    output logic                          busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BIT_VEC_SIZE_LOG:0] CAP = BIT_VEC_SIZE[BIT_VEC_SIZE_LOG:0];
    localparam logic [TW-1:0] TMAX = TIMEOUT[TW-1:0];
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic prefer_upd;
    logic [TW-1:0] timer;
    logic idle, grant_upd, grant_rd;
    assign idle      = (state == IDLE) && !rst;
    assign grant_upd = idle && upd_valid && (!rd_valid || prefer_upd);
    assign grant_rd  = idle && rd_valid && !grant_upd;
    assign upd_ready = grant_upd;
    assign rd_ready  = grant_rd;
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            prefer_upd    <= 1'b1;
            timer         <= '0;
            sm_opcode     <= 3'b111;
            sm_opcode_in  <= 3'b111;
            sm_id         <= '0;
            sm_metric_val <= '0;
            sm_in         <= '0;
            sm_metricX    <= '0;
            rsp_valid     <= 1'b0;
            rsp_kind      <= 2'd0;
            rsp_status    <= 2'd0;
            occupancy     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (grant_upd || grant_rd) begin
                    prefer_upd <= grant_rd;
                    rsp_kind   <= grant_rd ? 2'd2 : {1'b0, upd_op};
                    if (grant_upd) begin
                        sm_id         <= upd_id;
                        sm_metric_val <= upd_metric;
                        sm_opcode_in  <= 3'b111;
                    end else begin
                        sm_in        <= rd_mask;
                        sm_metricX   <= rd_metric;
                        sm_opcode_in <= rd_filter ? 3'b010 : 3'b101;
                    end
                    // Overflow/underflow rejects skip the smbm entirely
                    if (grant_upd && !upd_op && occupancy == CAP) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= 2'd1;
                    end else if (grant_upd && upd_op && occupancy == '0) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= 2'd2;
                    end else begin
                        state     <= ISSUE;
                        sm_opcode <= grant_rd ? 3'b010 : {2'b00, upd_op};
                    end
                end
                ISSUE: begin
                    sm_opcode <= 3'b111;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: if (sm_done) begin
                    occupancy  <= rsp_kind == 2'd0 ? occupancy + 1'b1 :
                                  rsp_kind == 2'd1 ? occupancy - 1'b1 : occupancy;
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_status <= 2'd0;
                end else if (timer == TMAX) begin
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_status <= 2'd3;
                end else begin
                    timer <= timer + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smbm_ctrl.sv
// tb_smbm_ctrl: directed bench for smbm_ctrl with a small smbm done responder
// (READ done one cycle after issue, ADD/DELETE two cycles after issue).
module tb_smbm_ctrl;
    logic clk = 0, rst = 1;
    logic upd_valid = 0, upd_op = 0, rd_valid = 0, rd_filter = 0;
    logic [7:0] upd_id = 0;
    logic [31:0] upd_metric = 0;
    logic [255:0] rd_mask = 0;
    logic [1:0] rd_metric = 0;
    logic upd_ready, rd_ready, rsp_valid, busy;
    logic [2:0] sm_opcode, sm_opcode_in;
    logic [7:0] sm_id;
    logic [31:0] sm_metric_val;
    logic [255:0] sm_in;
    logic [1:0] sm_metricX, rsp_kind, rsp_status;
    logic [8:0] occupancy;
    logic sm_done = 0, done_en = 1;
    int cnt = 0, n_checks = 0, n_fail = 0, exp_occ = 0;

    smbm_ctrl dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
        .upd_id(upd_id), .upd_metric(upd_metric), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_mask(rd_mask), .rd_metric(rd_metric), .rd_filter(rd_filter), .sm_opcode(sm_opcode),
        .sm_id(sm_id), .sm_metric_val(sm_metric_val), .sm_in(sm_in), .sm_metricX(sm_metricX),
        .sm_opcode_in(sm_opcode_in), .sm_done(sm_done), .rsp_valid(rsp_valid), .rsp_kind(rsp_kind),
        .rsp_status(rsp_status), .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            sm_done = 0;
            cnt = 0;
        end else begin
            sm_done = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) sm_done = 1;
            end
            if (done_en && sm_opcode !== 3'b111) cnt = (sm_opcode == 3'b010) ? 1 : 2;
        end
    end

    task automatic run_req(input logic uv, input logic rv, input logic op, input logic [7:0] id,
                           input logic [31:0] m, input logic flt, output logic gu, output logic gr,
                           output int lat, output int n_iss, output logic [2:0] opc,
                           output logic [2:0] opc_in, output logic [1:0] kind, output logic [1:0] st);
        gu = 0; gr = 0; lat = -1; n_iss = 0; opc = 3'b111; opc_in = 3'b111; kind = 0; st = 0;
        @(negedge clk);
        if (uv) begin upd_valid = 1; upd_op = op; upd_id = id; upd_metric = m; end
        if (rv) begin rd_valid = 1; rd_filter = flt; rd_mask = {32{id}}; rd_metric = id[1:0]; end
        #1;
        for (int i = 0; i < 40 && !(upd_ready || rd_ready); i++) begin @(negedge clk); #1; end
        gu = upd_ready; gr = rd_ready;
        if (!(gu || gr)) return;
        @(posedge clk); #1;
        if (gu) upd_valid = 0;
        if (gr) rd_valid = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            if (sm_opcode !== 3'b111) begin n_iss++; opc = sm_opcode; opc_in = sm_opcode_in; end
            if (rsp_valid) begin lat = i; kind = rsp_kind; st = rsp_status; break; end
        end
    endtask

    logic gu, gr;
    int lat, n_iss;
    logic [2:0] opc, opc_in;
    logic [1:0] kind, st;

    task automatic test_reset();
        rst = 1; upd_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (upd_ready !== 0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", upd_ready); end
        n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (sm_opcode !== 3'b111 || sm_opcode_in !== 3'b111) begin n_fail++; $display("FAIL reset_opcodes got %b/%b want 111/111", sm_opcode, sm_opcode_in); end
        n_checks++; if (occupancy !== 0 || rsp_valid !== 0 || sm_id !== 0) begin n_fail++; $display("FAIL reset_regs got occ=%0d rsp=%0b id=%0d want 0", occupancy, rsp_valid, sm_id); end
        upd_valid = 0; rst = 0;
    endtask

    task automatic test_delete_empty();
        run_req(1, 0, 1, 8'd3, 0, 0, gu, gr, lat, n_iss, opc, opc_in, kind, st);
        n_checks++; if (gu !== 1) begin n_fail++; $display("FAIL del_empty_grant got %0b want 1", gu); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL del_empty_lat got %0d want 1", lat); end
        n_checks++; if (st !== 2 || kind !== 1) begin n_fail++; $display("FAIL del_empty_rsp got st=%0d kind=%0d want 2/1", st, kind); end
        n_checks++; if (n_iss !== 0 || occupancy !== 0) begin n_fail++; $display("FAIL del_empty_noissue got iss=%0d occ=%0d want 0/0", n_iss, occupancy); end
    endtask

    task automatic test_add();
        run_req(1, 0, 0, 8'd5, 32'h281E140A, 0, gu, gr, lat, n_iss, opc, opc_in, kind, st);
        n_checks++; if (gu !== 1) begin n_fail++; $display("FAIL add_ready got %0b want 1", gu); end
        n_checks++; if (n_iss !== 1 || opc !== 3'b000) begin n_fail++; $display("FAIL add_issue got n=%0d op=%b want 1/000", n_iss, opc); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_lat got %0d want 4", lat); end
        n_checks++; if (kind !== 0 || st !== 0) begin n_fail++; $display("FAIL add_rsp got kind=%0d st=%0d want 0/0", kind, st); end
        n_checks++; if (occupancy !== 1) begin n_fail++; $display("FAIL add_occ got %0d want 1", occupancy); end
        n_checks++; if (sm_id !== 5 || sm_metric_val !== 32'h281E140A) begin n_fail++; $display("FAIL add_args got id=%0d m=%h want 5/281e140a", sm_id, sm_metric_val); end
        exp_occ = 1;
    endtask

    task automatic test_arbitration();
        run_req(0, 1, 0, 8'd9, 0, 0, gu, gr, lat, n_iss, opc, opc_in, kind, st);
        n_checks++; if (gr !== 1 || lat !== 3 || kind !== 2) begin n_fail++; $display("FAIL read_single got g=%0b lat=%0d kind=%0d want 1/3/2", gr, lat, kind); end
        n_checks++; if (opc !== 3'b010 || opc_in !== 3'b101) begin n_fail++; $display("FAIL read_unmasked got %b/%b want 010/101", opc, opc_in); end
        n_checks++; if (sm_in !== {32{8'd9}} || sm_metricX !== 2'd1) begin n_fail++; $display("FAIL read_args got mX=%0d want 1", sm_metricX); end
        for (int k = 0; k < 4; k++) begin
            run_req(1, 1, 0, 8'(20 + k), 32'(k), k == 1, gu, gr, lat, n_iss, opc, opc_in, kind, st);
            if (k % 2 == 0) begin
                n_checks++; if (gu !== 1 || lat !== 4 || kind !== 0) begin n_fail++; $display("FAIL rr_upd%0d got g=%0b lat=%0d kind=%0d want 1/4/0", k, gu, lat, kind); end
                exp_occ++;
            end else begin
                n_checks++; if (gr !== 1 || lat !== 3 || kind !== 2) begin n_fail++; $display("FAIL rr_rd%0d got g=%0b lat=%0d kind=%0d want 1/3/2", k, gr, lat, kind); end
                n_checks++; if (opc_in !== (k == 1 ? 3'b010 : 3'b101)) begin n_fail++; $display("FAIL rr_opcin%0d got %b", k, opc_in); end
            end
        end
        upd_valid = 0; rd_valid = 0;
        n_checks++; if (occupancy !== 9'(exp_occ)) begin n_fail++; $display("FAIL rr_occ got %0d want %0d", occupancy, exp_occ); end
    endtask

    task automatic test_fill();
        while (exp_occ < 256) begin
            run_req(1, 0, 0, 8'(exp_occ), 32'(exp_occ), 0, gu, gr, lat, n_iss, opc, opc_in, kind, st);
            n_checks++; if (lat !== 4 || st !== 0) begin n_fail++; $display("FAIL fill_%0d got lat=%0d st=%0d want 4/0", exp_occ, lat, st); end
            exp_occ++;
        end
        n_checks++; if (occupancy !== 9'd256) begin n_fail++; $display("FAIL full_occ got %0d want 256", occupancy); end
        run_req(1, 0, 0, 8'd1, 0, 0, gu, gr, lat, n_iss, opc, opc_in, kind, st);
        n_checks++; if (lat !== 1 || st !== 1 || n_iss !== 0) begin n_fail++; $display("FAIL add_full got lat=%0d st=%0d iss=%0d want 1/1/0", lat, st, n_iss); end
        n_checks++; if (occupancy !== 9'd256) begin n_fail++; $display("FAIL add_full_occ got %0d want 256", occupancy); end
        run_req(1, 0, 1, 8'd1, 0, 0, gu, gr, lat, n_iss, opc, opc_in, kind, st);
        n_checks++; if (lat !== 4 || st !== 0 || opc !== 3'b001) begin n_fail++; $display("FAIL del_full got lat=%0d st=%0d op=%b want 4/0/001", lat, st, opc); end
        n_checks++; if (occupancy !== 9'd255) begin n_fail++; $display("FAIL del_occ got %0d want 255", occupancy); end
    endtask

    task automatic test_timeout();
        done_en = 0;
        run_req(1, 0, 1, 8'd2, 0, 0, gu, gr, lat, n_iss, opc, opc_in, kind, st);
        done_en = 1;
        n_checks++; if (lat !== 18 || st !== 3) begin n_fail++; $display("FAIL timeout got lat=%0d st=%0d want 18/3", lat, st); end
        n_checks++; if (occupancy !== 9'd255) begin n_fail++; $display("FAIL timeout_occ got %0d want 255", occupancy); end
        run_req(0, 1, 0, 8'd4, 0, 1, gu, gr, lat, n_iss, opc, opc_in, kind, st);
        n_checks++; if (gr !== 1 || lat !== 3 || st !== 0) begin n_fail++; $display("FAIL after_timeout got g=%0b lat=%0d st=%0d want 1/3/0", gr, lat, st); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        upd_valid = 1; upd_op = 0; upd_id = 8'd7;
        @(posedge clk); #1;
        upd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 0 || occupancy !== 0) begin n_fail++; $display("FAIL rst_mid got busy=%0b occ=%0d want 0/0", busy, occupancy); end
        n_checks++; if (sm_opcode !== 3'b111 || rsp_valid !== 0) begin n_fail++; $display("FAIL rst_mid_out got op=%b rsp=%0b want 111/0", sm_opcode, rsp_valid); end
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_delete_empty();
        test_add();
        test_arbitration();
        test_fill();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/smbm_ctrl.md
Name: smbm_ctrl

Overview:
- Command sequencer and arbiter in front of one smbm sorted-metric list instance.
- Accepts ADD/DELETE requests from the update requester and READ requests from the query requester, and arbitrates round-robin between them.
- Issues one smbm operation at a time with correct opcode pulse timing, holds arguments stable until done, tracks list occupancy, rejects overflow/underflow, and reports per-command status with a done-watchdog.

Parameters:
- BIT_VEC_SIZE, 256, list capacity (entries).
- BIT_VEC_SIZE_LOG, 8, log2(BIT_VEC_SIZE).
- NUM_OF_METRICS, 4, metrics per entry.
- NUM_OF_METRICS_LOG, 2, log2(NUM_OF_METRICS).
- TIMEOUT, 15, max WAIT cycles for sm_done before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- upd_valid  in  1  update request valid
- upd_ready  out  1  update request accepted this cycle
- upd_op  in  1  0=ADD, 1=DELETE
- upd_id  in  BIT_VEC_SIZE_LOG  entry id
- upd_metric  in  8*NUM_OF_METRICS  metric values, metric k in bits [8k+7:8k]
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted this cycle
- rd_mask  in  BIT_VEC_SIZE  id filter vector
- rd_metric  in  NUM_OF_METRICS_LOG  metric list to read
- rd_filter  in  1  1=masked read (opcode_in 3'b010), 0=unmasked (3'b101)
- sm_opcode  out  3  to smbm opcode: 000 ADD, 001 DELETE, 010 READ, 111 NOP
- sm_id  out  BIT_VEC_SIZE_LOG  to smbm id
- sm_metric_val  out  8*NUM_OF_METRICS  to smbm metric_val
- sm_in  out  BIT_VEC_SIZE  to smbm in
- sm_metricX  out  NUM_OF_METRICS_LOG  to smbm metricX
- sm_opcode_in  out  3  to smbm opcode_in
- sm_done  in  1  from smbm done
- rsp_valid  out  1  one-cycle completion pulse
- rsp_kind  out  2  0=ADD, 1=DELETE, 2=READ
- rsp_status  out  2  0=OK, 1=FULL reject, 2=EMPTY reject, 3=TIMEOUT
- occupancy  out  BIT_VEC_SIZE_LOG+1  current entry count
- busy  out  1  high in any state but IDLE

Behaviour:
- Reset values:
  - State IDLE, sm_opcode=111, sm_opcode_in=111.
  - All other sm_* outputs 0; rsp_valid/rsp_kind/rsp_status 0; occupancy 0.
  - upd_ready=rd_ready=0, busy=0.
  - Round-robin pointer favours update first.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Only one requester is granted per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - ready is asserted combinationally for the granted requester only; handshake = valid&ready.
  - On accept: latch all arguments into the sm_* registers and rsp_kind; update the RR pointer.
  - ADD with occupancy==BIT_VEC_SIZE goes to RESP with status 1, no smbm issue.
  - DELETE with occupancy==0 goes to RESP with status 2, no smbm issue.
  - Otherwise go to ISSUE.
- ISSUE:
  - sm_opcode = latched op for exactly one cycle.
  - sm_opcode_in = 010/101 for reads, 111 for updates.
  - Next state WAIT; timer cleared.
- WAIT:
  - sm_opcode=111; sm_* arguments held stable.
  - On sm_done=1: ADD occupancy+1, DELETE occupancy-1, READ unchanged; go to RESP with status 0.
  - Else if timer==TIMEOUT: go to RESP with status 3, occupancy unchanged.
  - Otherwise timer+1.
  - sm_done takes priority over timeout in the same cycle.
- RESP:
  - rsp_valid=1 for one cycle; rsp_kind/rsp_status hold until the next RESP.
  - Next state IDLE; no backpressure.
  - For READ, the smbm out_list is valid from the RESP cycle.
- Latency, accept at cycle T:
  - ADD/DELETE rsp_valid at T+4.
  - READ rsp_valid at T+3.
  - Reject rsp_valid at T+1.
  - Minimum issue spacing: 4 cycles (READ) and 5 cycles (update), guaranteeing smbm returns to its idle state before the next opcode.
- Requests arriving while busy are held by the requester; valid may not drop before ready.
- Duplicate-id ADD and absent-id DELETE are not detected; they are counted as OK.
- occupancy never wraps: it saturates at 0 and BIT_VEC_SIZE by construction of the rejects.
- rst mid-operation returns to IDLE immediately with all reset values; smbm shares rst.

Test Plan:
- Reset, then a single ADD id=5 with metrics {10,20,30,40} -> upd_ready at T, sm_opcode=000 only at T+1, rsp_valid at T+4 with kind 0, status 0; occupancy=1.
- DELETE with occupancy=0 -> rsp at T+1, status 2, sm_opcode stays 111, occupancy 0.
- Update and read valid together for 4 consecutive grants -> grants alternate update, read, update, read; reads complete T+3 with kind 2 and sm_opcode_in 010 when rd_filter=1, 101 when 0.
- Fill to 256 ADDs, then ADD -> status 1, occupancy remains 256; one DELETE -> occupancy 255.
- sm_done tied 0 after issue -> rsp at T+1+1+TIMEOUT+1 with status 3, occupancy unchanged; next request is accepted normally.
- rst asserted in WAIT -> next cycle busy=0, occupancy=0, sm_opcode=111, no rsp_valid.
